// File: rtl/decode_ctrl_stage.sv
// Instruction-decode stage: decodes an RV32I(+M) word into the control bundle and
// holds it in the ID/EX register, with load-use bubble insertion, flush and stall.
module decode_ctrl_stage #(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            RegWrite,
    output logic            ALUsrc,
    output logic            MemWrite,
    output logic            destsrc,
    output logic [3:0]      ALUctrl,
    output logic [2:0]      ImmSrc,
    output logic [2:0]      memCtrl,
    output logic            is_branch,
    output logic            is_jal,
    output logic            is_jalr,
    output logic            is_lui,
    output logic            is_auipc,
    output logic            mdu_en,
    output logic [2:0]      mdu_op,
    output logic            illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_B = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_in;
    logic [4:0] rs1_in;
    logic [4:0] rs2_in;

    assign opcode = instr[6:0];
    assign rd_in  = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1_in = instr[19:15];
    assign rs2_in = instr[24:20];
    assign funct7 = instr[31:25];

    logic       d_reg_write;
    logic       d_alu_src;
    logic       d_mem_write;
    logic       d_dest_src;
    logic [3:0] d_alu_ctrl;
    logic [2:0] d_imm_src;
    logic       d_branch;
    logic       d_jal;
    logic       d_jalr;
    logic       d_lui;
    logic       d_auipc;
    logic       d_mdu_en;
    logic [2:0] d_mdu_op;
    logic       d_bad;
    logic       uses_rs1;
    logic       uses_rs2;

    always_comb begin
        d_reg_write = 1'b0;
        d_alu_src   = 1'b0;
        d_mem_write = 1'b0;
        d_dest_src  = 1'b0;
        d_alu_ctrl  = 4'd0;
        d_imm_src   = IMM_I;
        d_branch    = 1'b0;
        d_jal       = 1'b0;
        d_jalr      = 1'b0;
        d_lui       = 1'b0;
        d_auipc     = 1'b0;
        d_mdu_en    = 1'b0;
        d_mdu_op    = 3'd0;
        d_bad       = 1'b0;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b0;

        case (opcode)
            OP_R: begin
                d_reg_write = 1'b1;
                uses_rs2    = 1'b1;
                d_alu_ctrl  = {instr[30], funct3};
                if (EN_M && funct7 == F7_MUL) begin
                    d_mdu_en   = 1'b1;
                    d_mdu_op   = funct3;
                    d_alu_ctrl = 4'd0;
                end else if (funct7 == F7_ALT) begin
                    // Only SUB and SRA have an alternate encoding.
                    d_bad = !(funct3 == 3'b000 || funct3 == 3'b101);
                end else if (funct7 != F7_BASE) begin
                    d_bad = 1'b1;
                end
            end
            OP_IMM: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_alu_ctrl  = {(funct3 == 3'b101) & instr[30], funct3};
            end
            OP_LOAD: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_dest_src  = 1'b1;
            end
            OP_BRANCH: begin
                d_imm_src  = IMM_B;
                d_alu_ctrl = {1'b0, funct3};
                d_branch   = 1'b1;
                uses_rs2   = 1'b1;
                d_bad      = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_STORE: begin
                d_mem_write = 1'b1;
                d_alu_src   = 1'b1;
                d_imm_src   = IMM_S;
                uses_rs2    = 1'b1;
            end
            OP_LUI: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_imm_src   = IMM_U;
                d_lui       = 1'b1;
                uses_rs1    = 1'b0;
            end
            OP_AUIPC: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_imm_src   = IMM_U;
                d_auipc     = 1'b1;
                uses_rs1    = 1'b0;
            end
            OP_JAL: begin
                d_reg_write = 1'b1;
                d_imm_src   = IMM_J;
                d_jal       = 1'b1;
                uses_rs1    = 1'b0;
            end
            OP_JALR: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_imm_src   = IMM_I;
                d_jalr      = 1'b1;
                d_bad       = (funct3 != 3'b000);
            end
            default: d_bad = 1'b1;
        endcase

        // Illegal words still flow downstream but must not change architectural state.
        d_reg_write = d_reg_write & ~d_bad;
        d_mem_write = d_mem_write & ~d_bad;
        d_mdu_en    = d_mdu_en & ~d_bad;
    end

    logic hz;
    logic accept;

    assign hz = out_valid && destsrc && (rd != 5'd0) && in_valid &&
                ((uses_rs1 && rs1_in == rd) || (uses_rs2 && rs2_in == rd));

    assign in_ready = flush | ((~out_valid | out_ready) & ~hz);
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            pc_out    <= '0;
            rd        <= 5'd0;
            rs1       <= 5'd0;
            rs2       <= 5'd0;
            RegWrite  <= 1'b0;
            ALUsrc    <= 1'b0;
            MemWrite  <= 1'b0;
            destsrc   <= 1'b0;
            ALUctrl   <= 4'd0;
            ImmSrc    <= 3'd0;
            memCtrl   <= 3'd0;
            is_branch <= 1'b0;
            is_jal    <= 1'b0;
            is_jalr   <= 1'b0;
            is_lui    <= 1'b0;
            is_auipc  <= 1'b0;
            mdu_en    <= 1'b0;
            mdu_op    <= 3'd0;
            illegal   <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                pc_out    <= pc_in;
                rd        <= rd_in;
                rs1       <= rs1_in;
                rs2       <= rs2_in;
                RegWrite  <= d_reg_write;
                ALUsrc    <= d_alu_src;
                MemWrite  <= d_mem_write;
                destsrc   <= d_dest_src;
                ALUctrl   <= d_alu_ctrl;
                ImmSrc    <= d_imm_src;
                memCtrl   <= funct3;
                is_branch <= d_branch;
                is_jal    <= d_jal;
                is_jalr   <= d_jalr;
                is_lui    <= d_lui;
                is_auipc  <= d_auipc;
                mdu_en    <= d_mdu_en;
                mdu_op    <= d_mdu_op;
                illegal   <= d_bad;
            end
        end
    end

endmodule
